// File: rtl/vga_io_pkg.sv
// Shared types, VGA port constants and byte-lane helpers for the host I/O bus master.
package vga_io_pkg;

   typedef enum logic [1:0] {StIdle, StStrobe, StRecover, StResp} io_state_e;

   localparam logic [15:0] PORT_CRTC_IDX_MONO   = 16'h03B4;
   localparam logic [15:0] PORT_CRTC_DATA_MONO  = 16'h03B5;
   localparam logic [15:0] PORT_SEQ_IDX         = 16'h03C4;
   localparam logic [15:0] PORT_SEQ_DATA        = 16'h03C5;
   localparam logic [15:0] PORT_CRTC_IDX_COLOR  = 16'h03D4;
   localparam logic [15:0] PORT_CRTC_DATA_COLOR = 16'h03D5;

   // Odd byte lives on the upper lane of the 16-bit bus.
   function automatic logic [15:0] lane_steer_wr(input logic size16, input logic addr0,
                                                 input logic [15:0] wdata);
      case ({size16, addr0})
         2'b10:   return wdata;
         2'b00:   return {8'h00, wdata[7:0]};
         2'b01:   return {wdata[7:0], 8'h00};
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] lane_extract_rd(input logic size16, input logic addr0,
                                                   input logic [15:0] bus);
      case ({size16, addr0})
         2'b10:   return bus;
         2'b00:   return {8'h00, bus[7:0]};
         2'b01:   return {8'h00, bus[15:8]};
         default: return 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/vga_io_lane_align.sv
// Combinational byte-lane steering for writes and right-justified extraction for reads.
module vga_io_lane_align
   import vga_io_pkg::*;
(
   input  logic        size16,
   input  logic        addr0,
   input  logic [15:0] wdata,
   input  logic [15:0] io_rdata,
   output logic [15:0] dbus,
   output logic [15:0] rdata
);

   always_comb begin
      dbus  = lane_steer_wr(size16, addr0, wdata);
      rdata = lane_extract_rd(size16, addr0, io_rdata);
   end

endmodule

// File: rtl/vga_host_io_master.sv
// Host-side initiator for the VGA I/O register bus: one request at a time, strobe/recover/respond.
// Optional strobe timeout is enabled by defining IO_TIMEOUT_EN.
module vga_host_io_master
   import vga_io_pkg::*;
#(
   parameter int unsigned MIN_STROBE     = 2,
   parameter int unsigned RECOVERY       = 1,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        h_hclk,
   input  logic        h_reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic        req_size16,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic [15:0] h_io_addr,
   output logic [15:0] h_io_dbus,
   output logic        h_iowr,
   output logic        h_iord,
   output logic        h_io_16,
   input  logic [15:0] io_rdata,
   input  logic        io_ready_n
);

`ifdef IO_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   // Strobe counter saturates so a long wait can never wrap below MIN_STROBE.
   localparam int unsigned SCNT_MAX = (TIMEOUT_EN && TIMEOUT_CYCLES > MIN_STROBE) ?
                                      TIMEOUT_CYCLES : MIN_STROBE;
   localparam int unsigned SCNT_W   = $clog2(SCNT_MAX + 1);

   io_state_e         state_q;
   logic [SCNT_W-1:0] scnt_q;
   logic [3:0]        rcnt_q;
   logic              write_q;
   logic [15:0]       wdata_q;
   logic [15:0]       rd_ext;

   // Keyed by the bus-cycle registers so dbus stays stable through STROBE and RECOVER.
   vga_io_lane_align u_lane_align (
      .size16   (h_io_16),
      .addr0    (h_io_addr[0]),
      .wdata    (wdata_q),
      .io_rdata (io_rdata),
      .dbus     (h_io_dbus),
      .rdata    (rd_ext)
   );

   always_ff @(posedge h_hclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         state_q   <= StIdle;
         scnt_q    <= '0;
         rcnt_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         h_io_addr <= '0;
         h_iowr    <= 1'b0;
         h_iord    <= 1'b0;
         h_io_16   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  write_q   <= req_write;
                  if (req_size16 && req_addr[0]) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     state_q   <= StResp;
                  end else begin
                     h_io_addr <= req_addr;
                     h_io_16   <= req_size16;
                     wdata_q   <= req_write ? req_wdata : 16'h0000;
                     h_iowr    <= req_write;
                     h_iord    <= !req_write;
                     scnt_q    <= SCNT_W'(1);
                     state_q   <= StStrobe;
                  end
               end
            end
            StStrobe: begin
               if (scnt_q >= SCNT_W'(MIN_STROBE) && !io_ready_n) begin
                  h_iowr    <= 1'b0;
                  h_iord    <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= write_q ? 16'h0000 : rd_ext;
                  rcnt_q    <= 4'd1;
                  state_q   <= StRecover;
               end else if (TIMEOUT_EN && scnt_q == SCNT_W'(TIMEOUT_CYCLES)) begin
                  h_iowr    <= 1'b0;
                  h_iord    <= 1'b0;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= write_q ? 16'h0000 : 16'hFFFF;
                  rcnt_q    <= 4'd1;
                  state_q   <= StRecover;
               end else if (scnt_q != SCNT_W'(SCNT_MAX)) begin
                  scnt_q <= scnt_q + SCNT_W'(1);
               end
            end
            StRecover: begin
               if (rcnt_q >= 4'(RECOVERY)) begin
                  rsp_valid <= 1'b1;
                  state_q   <= StResp;
               end else begin
                  rcnt_q <= rcnt_q + 4'd1;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  scnt_q    <= '0;
                  rcnt_q    <= '0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_host_io_master.sv
// Self-checking bench for vga_host_io_master: directed cases plus randomized requests.
module tb_vga_host_io_master;
   import vga_io_pkg::*;

   localparam int MIN_STROBE = 2;
   localparam int RECOVERY   = 1;
   localparam int TIMEOUT    = 64;
`ifdef IO_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        h_hclk = 1'b0;
   logic        h_reset_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_size16 = 1'b0;
   logic [15:0] req_addr = '0, req_wdata = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [15:0] rsp_rdata, h_io_addr, h_io_dbus, io_rdata = '0;
   logic        h_iowr, h_iord, h_io_16, io_ready_n = 1'b1;

   int passed = 0, failed = 0, total = 0;

   vga_host_io_master dut (
      .h_hclk     (h_hclk),
      .h_reset_n  (h_reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_size16 (req_size16),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .h_io_addr  (h_io_addr),
      .h_io_dbus  (h_io_dbus),
      .h_iowr     (h_iowr),
      .h_iord     (h_iord),
      .h_io_16    (h_io_16),
      .io_rdata   (io_rdata),
      .io_ready_n (io_ready_n)
   );

   always #5 h_hclk = ~h_hclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {10'd0, req_ready, rsp_valid, rsp_rdata, rsp_err, h_io_addr, h_io_dbus,
              h_iowr, h_iord, h_io_16};
   endfunction

   task automatic wait_req_ready(input string tag);
      bit ok = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge h_hclk);
         if (req_ready) begin
            ok = 1;
            break;
         end
      end
      check({tag, "_req_ready"}, 64'(ok), 64'd1);
   endtask

   // Reference: strobe lasts until the first cycle >= MIN_STROBE whose ready_n is low,
   // cycle n using mask bit min(n-1,31); optionally capped by the timeout.
   task automatic run_txn(input string tag, input logic wr, input logic s16,
                          input logic [15:0] addr, input logic [15:0] wd,
                          input logic [15:0] bus_rd, input logic [31:0] mask, input int hold);
      bit mis, to, got, bus_ok, hold_ok;
      int exp_len, exp_lat, n, low_after, lat;
      logic [15:0] exp_dbus, exp_rd;
      mis = s16 && addr[0];
      to = 0;
      exp_len = 0;
      if (!mis) begin
         for (int k = MIN_STROBE; k < 1000; k++) begin
            if (mask[(k - 1 > 31) ? 31 : k - 1]) begin
               exp_len = k;
               break;
            end
            if (TO_EN && k == TIMEOUT) begin
               exp_len = k;
               to = 1;
               break;
            end
         end
      end
      exp_dbus = s16 ? wd : (16'(wd[7:0]) << (addr[0] ? 8 : 0));
      if (wr || mis)  exp_rd = 16'h0000;
      else if (to)    exp_rd = 16'hFFFF;
      else if (s16)   exp_rd = bus_rd;
      else            exp_rd = (bus_rd >> (addr[0] ? 8 : 0)) & 16'h00FF;
      exp_lat = mis ? 1 : exp_len + RECOVERY + 1;

      wait_req_ready(tag);
      req_write = wr; req_size16 = s16; req_addr = addr; req_wdata = wd;
      io_rdata = bus_rd; io_ready_n = 1'b1; req_valid = 1'b1;
      @(posedge h_hclk);
      #1 req_valid = 1'b0;
      req_addr = 16'hDEAD; req_wdata = 16'hBEEF; req_write = ~wr;

      n = 0; low_after = 0; got = 0; lat = 0; bus_ok = 1;
      for (int c = 0; c < 300; c++) begin
         @(negedge h_hclk);
         if (rsp_valid) begin
            got = 1;
            lat = c + 1;
            break;
         end
         if (h_iowr || h_iord) begin
            n++;
            if (low_after != 0 || h_iowr !== wr || h_iord !== !wr || h_io_addr !== addr ||
                h_io_16 !== s16 || (wr && h_io_dbus !== exp_dbus)) bus_ok = 0;
            io_ready_n = !mask[(n - 1 > 31) ? 31 : n - 1];
         end else begin
            if (n > 0) begin
               low_after++;
               if (h_io_addr !== addr || h_io_16 !== s16) bus_ok = 0;
            end
            io_ready_n = 1'b1;
         end
      end
      io_ready_n = 1'b1;
      check({tag, "_rsp_seen"}, 64'(got), 64'd1);
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_strobe_len"}, 64'(n), 64'(exp_len));
      check({tag, "_recover"}, 64'(low_after), 64'(mis ? 0 : RECOVERY));
      check({tag, "_bus"}, 64'(bus_ok), 64'd1);
      check({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
      check({tag, "_err"}, 64'(rsp_err), 64'(mis || to));

      hold_ok = 1;
      for (int h = 0; h < hold; h++) begin
         @(negedge h_hclk);
         if (!rsp_valid || req_ready || rsp_rdata !== exp_rd) hold_ok = 0;
      end
      if (hold > 0) check({tag, "_hold"}, 64'(hold_ok), 64'd1);
      rsp_ready = 1'b1;
      @(posedge h_hclk);
      #1 rsp_ready = 1'b0;
      check({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      logic [31:0] r;
      #12;
      check("reset_outs", all_outs(), 64'd0);
      @(negedge h_hclk);
      h_reset_n = 1'b1;

      run_txn("wr16_seq", 1'b1, 1'b1, PORT_SEQ_IDX, 16'h0F02, 16'h0000, 32'hFFFF_FFFE, 0);
      run_txn("rd8_odd", 1'b0, 1'b0, PORT_SEQ_DATA, 16'h0000, 16'hA55A, 32'hFFFF_FFFF, 0);
      run_txn("wr8_late", 1'b1, 1'b0, PORT_CRTC_IDX_COLOR, 16'h0011, 16'h0000,
              32'hFFFF_FFF9, 0);
      run_txn("rd16_mis", 1'b0, 1'b1, PORT_SEQ_DATA, 16'h0000, 16'h1234, 32'hFFFF_FFFF, 0);
      run_txn("rd8_even", 1'b0, 1'b0, PORT_CRTC_IDX_MONO, 16'h0000, 16'hC33C, 32'hFFFF_FFFF, 2);
      run_txn("wr8_odd", 1'b1, 1'b0, PORT_CRTC_DATA_COLOR, 16'h77AB, 16'h0000, 32'hFFFF_FFFF, 0);
      run_txn("rd16_ok", 1'b0, 1'b1, PORT_CRTC_IDX_MONO, 16'h0000, 16'hBEA7, 32'hFFFF_FFF0, 1);
`ifdef IO_TIMEOUT_EN
      run_txn("rd_timeout", 1'b0, 1'b0, PORT_SEQ_DATA, 16'h0000, 16'h1234, 32'h0000_0000, 0);
`endif

      // Response held through 5 cycles of back-pressure, then reset in the middle of a strobe.
      run_txn("hold5", 1'b0, 1'b0, PORT_CRTC_DATA_MONO, 16'h0000, 16'h5AA5, 32'hFFFF_FFFF, 5);
      wait_req_ready("rst_mid");
      req_write = 1'b1; req_size16 = 1'b0; req_addr = PORT_SEQ_IDX; req_wdata = 16'h0055;
      io_ready_n = 1'b1; req_valid = 1'b1;
      @(posedge h_hclk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge h_hclk);
      check("rst_mid_strobe_on", 64'(h_iowr), 64'd1);
      #2 h_reset_n = 1'b0;
      #1 check("rst_mid_outs", all_outs(), 64'd0);
      @(negedge h_hclk);
      h_reset_n = 1'b1;
      repeat (3) @(negedge h_hclk);
      check("rst_mid_no_rsp", {62'd0, rsp_valid, req_ready}, 64'd1);

      for (int i = 0; i < 16; i++) begin
         r = $urandom;
         run_txn($sformatf("rand%0d", i), r[0], r[1],
                 r[2] ? 16'($urandom) : {15'h01E2, r[3]}, 16'($urandom), 16'($urandom),
                 $urandom | 32'h8000_0000, int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
